trap_ctrl: RTL and testbench

Trap sequencer and CP0 register owner for the 5-stage MIPS core. It consumes the prioritised `excepttype` produced at the memory stage and holds the pipeline while an outstanding data-SRAM access drains. It then commits the trap into Status/Cause/EPC/BadVAddr and issues a one-cycle flush plus PC redirect. It also implements Count/Compare and the MTC0/MFC0 ports, and exports `cp0_status`, `cp0_cause` and `epc_o` back to the exception prioritiser.

---
 rtl/trap_ctrl_if.sv | 37 +++
 rtl/trap_ctrl.sv | 162 ++++++++++++++++
 tb/tb_trap_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// Pipeline <-> trap sequencer / CP0 interface.
// master: pipeline side (drives trap info, MTC0/MFC0 requests, interrupt lines).
// slave : trap_ctrl (drives CP0 values, stall/flush/redirect).
interface trap_ctrl_if;
  logic [31:0] excepttype;
  logic [31:0] pcM;
  logic        is_in_delayslotM;
  logic [31:0] bad_addrM;
  logic        mem_busy;
  logic [5:0]  int_i;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [4:0]  cp0_raddr;
  logic [31:0] cp0_rdata;
  logic [31:0] cp0_status;
  logic [31:0] cp0_cause;
  logic [31:0] epc_o;
  logic        stall_req;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output excepttype, pcM, is_in_delayslotM, bad_addrM, mem_busy, int_i,
           cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
    input  cp0_rdata, cp0_status, cp0_cause, epc_o,
           stall_req, flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  excepttype, pcM, is_in_delayslotM, bad_addrM, mem_busy, int_i,
           cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
    output cp0_rdata, cp0_status, cp0_cause, epc_o,
           stall_req, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_ctrl.sv
// Trap sequencer and CP0 register owner.
// Ports: clk, rst (sync, active-high), trap_if (slave): memory-stage trap info,
// data-SRAM busy, interrupt lines, MTC0/MFC0 ports in; CP0 values,
// stall_req (combinational), flush / redirect_valid / redirect_pc (registered) out.
module trap_ctrl #(
  parameter logic [31:0] RESET_VECTOR_EXC = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RESET     = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  trap_ctrl_if.slave  trap_if
);

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] EXC_ADEL     = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES     = 32'h0000_0005;
  localparam logic [31:0] EXC_ERET     = 32'h0000_000E;
  localparam logic [4:0]  A_BADVADDR   = 5'd8;
  localparam logic [4:0]  A_COUNT      = 5'd9;
  localparam logic [4:0]  A_COMPARE    = 5'd11;
  localparam logic [4:0]  A_STATUS     = 5'd12;
  localparam logic [4:0]  A_CAUSE      = 5'd13;
  localparam logic [4:0]  A_EPC        = 5'd14;

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT} state_e;

  state_e      state_q;
  logic [31:0] status_q, cause_q, epc_q, badvaddr_q, count_q, compare_q;
  logic        tick_q;
  logic [31:0] lat_type_q, lat_pc_q, lat_bad_q;
  logic        lat_bd_q;
  logic        flush_q, redirect_valid_q;
  logic [31:0] redirect_pc_q;

  logic        trap_c, drain_c, stall_c, commit_c;
  logic [31:0] sel_type_c, sel_pc_c, sel_bad_c;
  logic        sel_bd_c, eret_c, addr_exc_c;
  logic        mtc_c, count_wr_c, cmp_wr_c, count_inc_c, ti_set_c;
  logic [31:0] count_d;

  // Trap detection, commit strobe and the trap fields used at commit.
  // In DRAIN the latched copy is used since the M stage may have moved on.
  always_comb begin
    trap_c     = (state_q == IDLE) && (trap_if.excepttype != 32'd0);
    drain_c    = (state_q == DRAIN);
    stall_c    = trap_c || drain_c;
    commit_c   = stall_c && !trap_if.mem_busy;
    sel_type_c = drain_c ? lat_type_q : trap_if.excepttype;
    sel_pc_c   = drain_c ? lat_pc_q   : trap_if.pcM;
    sel_bad_c  = drain_c ? lat_bad_q  : trap_if.bad_addrM;
    sel_bd_c   = drain_c ? lat_bd_q   : trap_if.is_in_delayslotM;
    eret_c     = (sel_type_c == EXC_ERET);
    addr_exc_c = (sel_type_c == EXC_ADEL) || (sel_type_c == EXC_ADES);
  end

  // MTC0 decode (dropped on a commit edge) and the Count/Compare timer.
  always_comb begin
    mtc_c       = trap_if.cp0_we && !commit_c;
    count_wr_c  = mtc_c && (trap_if.cp0_waddr == A_COUNT);
    cmp_wr_c    = mtc_c && (trap_if.cp0_waddr == A_COMPARE);
    count_inc_c = tick_q && !count_wr_c;
    count_d     = count_q;
    if (count_wr_c)       count_d = trap_if.cp0_wdata;
    else if (count_inc_c) count_d = count_q + 32'd1;
    // Match is checked on the increment edge against the new Count value.
    ti_set_c    = count_inc_c && (count_d == compare_q);
  end

  // Trap FSM and all CP0 state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      status_q         <= STATUS_RESET;
      cause_q          <= 32'd0;
      epc_q            <= 32'd0;
      badvaddr_q       <= 32'd0;
      count_q          <= 32'd0;
      compare_q        <= 32'd0;
      tick_q           <= 1'b0;
      lat_type_q       <= 32'd0;
      lat_pc_q         <= 32'd0;
      lat_bad_q        <= 32'd0;
      lat_bd_q         <= 1'b0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
    end else begin
      tick_q  <= ~tick_q;
      count_q <= count_d;

      // TI: a Compare write clears it, otherwise a match sets it.
      if (cmp_wr_c)      cause_q[30] <= 1'b0;
      else if (ti_set_c) cause_q[30] <= 1'b1;
      cause_q[15:10] <= {trap_if.int_i[5] | cause_q[30], trap_if.int_i[4:0]};

      if (mtc_c) begin
        case (trap_if.cp0_waddr)
          A_COMPARE: compare_q    <= trap_if.cp0_wdata;
          A_STATUS:  status_q     <= (status_q & ~STATUS_WMASK) | (trap_if.cp0_wdata & STATUS_WMASK);
          A_CAUSE:   cause_q[9:8] <= trap_if.cp0_wdata[9:8];
          A_EPC:     epc_q        <= trap_if.cp0_wdata;
          default: ;
        endcase
      end

      if (trap_c) begin
        lat_type_q <= trap_if.excepttype;
        lat_pc_q   <= trap_if.pcM;
        lat_bad_q  <= trap_if.bad_addrM;
        lat_bd_q   <= trap_if.is_in_delayslotM;
      end

      // CP0 commit; EPC/BD are frozen while already at exception level.
      if (commit_c) begin
        if (eret_c) begin
          status_q[1] <= 1'b0;
        end else begin
          cause_q[6:2] <= sel_type_c[4:0];
          if (!status_q[1]) begin
            epc_q       <= sel_bd_c ? sel_pc_c - 32'd4 : sel_pc_c;
            cause_q[31] <= sel_bd_c;
          end
          status_q[1] <= 1'b1;
          if (addr_exc_c) badvaddr_q <= sel_bad_c;
        end
      end

      flush_q          <= commit_c;
      redirect_valid_q <= commit_c;
      redirect_pc_q    <= commit_c ? (eret_c ? epc_q : RESET_VECTOR_EXC) : 32'd0;

      case (state_q)
        IDLE:    if (trap_c) state_q <= trap_if.mem_busy ? DRAIN : COMMIT;
        DRAIN:   if (!trap_if.mem_busy) state_q <= COMMIT;
        COMMIT:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // MFC0 read mux; not bypassed, writes show up the following cycle.
  always_comb begin
    case (trap_if.cp0_raddr)
      A_BADVADDR: trap_if.cp0_rdata = badvaddr_q;
      A_COUNT:    trap_if.cp0_rdata = count_q;
      A_COMPARE:  trap_if.cp0_rdata = compare_q;
      A_STATUS:   trap_if.cp0_rdata = status_q;
      A_CAUSE:    trap_if.cp0_rdata = cause_q;
      A_EPC:      trap_if.cp0_rdata = epc_q;
      default:    trap_if.cp0_rdata = 32'd0;
    endcase
  end

  assign trap_if.cp0_status     = status_q;
  assign trap_if.cp0_cause      = cause_q;
  assign trap_if.epc_o          = epc_q;
  assign trap_if.stall_req      = stall_c;
  assign trap_if.flush          = flush_q;
  assign trap_if.redirect_valid = redirect_valid_q;
  assign trap_if.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: vector table of single-cycle traps plus
// hand-written sequences for drain, timer, MTC0 collision and reset.
module tb_trap_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  trap_ctrl_if bus ();

  trap_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .trap_if (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] etype;
    logic [31:0] pc;
    logic        bd;
    logic [31:0] bad;
    logic [31:0] exp_rpc;
    logic [31:0] exp_epc;
    logic [4:0]  exp_exc;
    logic        exp_bd;
    logic        exp_exl;
    logic [31:0] exp_badv;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; ends at the negedge of the flush cycle.
  task automatic run_trap(input logic [31:0] t, input logic [31:0] pc,
                          input logic bd, input logic [31:0] bad);
    bus.excepttype       = t;
    bus.pcM              = pc;
    bus.is_in_delayslotM = bd;
    bus.bad_addrM        = bad;
    @(negedge clk);
    chk("trap_stall", 32'(bus.stall_req), 32'd1);
    chk("trap_noflush", 32'(bus.flush), 32'd0);
    next_cyc();
    bus.excepttype = 32'd0;
    @(negedge clk);
  endtask

  task automatic chk_quiet();
    next_cyc();
    @(negedge clk);
    chk("post_flush", 32'(bus.flush), 32'd0);
    chk("post_rvalid", 32'(bus.redirect_valid), 32'd0);
    chk("post_rpc", bus.redirect_pc, 32'd0);
  endtask

  initial begin
    logic found;
    vecs[0]  = '{32'h8, 32'hBFC00100, 1'b0, 32'h0,        32'hBFC00380, 32'hBFC00100, 5'h8, 1'b0, 1'b1, 32'h0};
    vecs[1]  = '{32'hE, 32'h11111111, 1'b0, 32'hFFFF0000, 32'hBFC00100, 32'hBFC00100, 5'h8, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{32'h4, 32'hBFC00204, 1'b1, 32'h00000003, 32'hBFC00380, 32'hBFC00200, 5'h4, 1'b1, 1'b1, 32'h3};
    vecs[3]  = '{32'hE, 32'h22222222, 1'b0, 32'hFFFF0000, 32'hBFC00200, 32'hBFC00200, 5'h4, 1'b1, 1'b0, 32'h3};
    vecs[4]  = '{32'h5, 32'h80000010, 1'b0, 32'h80001002, 32'hBFC00380, 32'h80000010, 5'h5, 1'b0, 1'b1, 32'h80001002};
    vecs[5]  = '{32'h8, 32'h80000040, 1'b1, 32'h12345678, 32'hBFC00380, 32'h80000010, 5'h8, 1'b0, 1'b1, 32'h80001002};
    vecs[6]  = '{32'hE, 32'h33333333, 1'b1, 32'hFFFF0000, 32'h80000010, 32'h80000010, 5'h8, 1'b0, 1'b0, 32'h80001002};
    vecs[7]  = '{32'hA, 32'h80000050, 1'b0, 32'hDEADBEEF, 32'hBFC00380, 32'h80000050, 5'hA, 1'b0, 1'b1, 32'h80001002};
    vecs[8]  = '{32'hE, 32'h44444444, 1'b0, 32'hFFFF0000, 32'h80000050, 32'h80000050, 5'hA, 1'b0, 1'b0, 32'h80001002};
    vecs[9]  = '{32'h1, 32'h80000060, 1'b1, 32'h0,        32'hBFC00380, 32'h8000005C, 5'h1, 1'b1, 1'b1, 32'h80001002};
    vecs[10] = '{32'hE, 32'h55555555, 1'b0, 32'hFFFF0000, 32'h8000005C, 32'h8000005C, 5'h1, 1'b1, 1'b0, 32'h80001002};

    rst = 1'b1;
    bus.excepttype = 32'd0; bus.pcM = 32'd0; bus.is_in_delayslotM = 1'b0;
    bus.bad_addrM = 32'd0; bus.mem_busy = 1'b0; bus.int_i = 6'd0;
    bus.cp0_we = 1'b0; bus.cp0_waddr = 5'd0; bus.cp0_wdata = 32'd0;
    bus.cp0_raddr = 5'd9;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_status", bus.cp0_status, 32'h00400000);
    chk("rst_cause", bus.cp0_cause, 32'h0);
    chk("rst_epc", bus.epc_o, 32'h0);
    chk("rst_count", bus.cp0_rdata, 32'h0);
    chk("rst_stall", 32'(bus.stall_req), 32'd0);
    chk("rst_flush", 32'(bus.flush), 32'd0);
    chk("rst_rvalid", 32'(bus.redirect_valid), 32'd0);
    chk("rst_rpc", bus.redirect_pc, 32'd0);
    next_cyc();
    rst = 1'b0;
    bus.cp0_raddr = 5'd8;

    // Single-cycle traps with mem_busy low
    for (int i = 0; i < 11; i++) begin
      next_cyc();
      run_trap(vecs[i].etype, vecs[i].pc, vecs[i].bd, vecs[i].bad);
      chk("v_flush", 32'(bus.flush), 32'd1);
      chk("v_rvalid", 32'(bus.redirect_valid), 32'd1);
      chk("v_stall_off", 32'(bus.stall_req), 32'd0);
      chk("v_rpc", bus.redirect_pc, vecs[i].exp_rpc);
      chk("v_epc", bus.epc_o, vecs[i].exp_epc);
      chk("v_exccode", 32'(bus.cp0_cause[6:2]), 32'(vecs[i].exp_exc));
      chk("v_bd", 32'(bus.cp0_cause[31]), 32'(vecs[i].exp_bd));
      chk("v_exl", 32'(bus.cp0_status[1]), 32'(vecs[i].exp_exl));
      chk("v_badvaddr", bus.cp0_rdata, vecs[i].exp_badv);
      chk_quiet();
    end

    // OV with mem_busy high for 3 cycles
    next_cyc();
    bus.excepttype = 32'hC; bus.pcM = 32'h80000100; bus.is_in_delayslotM = 1'b0;
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        next_cyc();
        bus.excepttype = 32'd0; bus.pcM = 32'h0; bus.is_in_delayslotM = 1'b1;
        bus.mem_busy = (i < 3);
      end
      @(negedge clk);
      chk("drain_stall", 32'(bus.stall_req), 32'd1);
      chk("drain_noflush", 32'(bus.flush), 32'd0);
      chk("drain_epc_hold", bus.epc_o, 32'h8000005C);
      chk("drain_exc_hold", 32'(bus.cp0_cause[6:2]), 32'h1);
    end
    next_cyc();
    bus.is_in_delayslotM = 1'b0;
    @(negedge clk);
    chk("drain_flush", 32'(bus.flush), 32'd1);
    chk("drain_stall_off", 32'(bus.stall_req), 32'd0);
    chk("drain_rpc", bus.redirect_pc, 32'hBFC00380);
    chk("drain_epc", bus.epc_o, 32'h80000100);
    chk("drain_exc", 32'(bus.cp0_cause[6:2]), 32'hC);
    chk_quiet();
    next_cyc();
    run_trap(32'hE, 32'h0, 1'b0, 32'h0);
    chk("drain_eret_rpc", bus.redirect_pc, 32'h80000100);
    chk("drain_eret_exl", 32'(bus.cp0_status[1]), 32'd0);
    chk_quiet();

    // Count/Compare timer
    bus.cp0_raddr = 5'd9;
    next_cyc();
    bus.cp0_we = 1'b1; bus.cp0_waddr = 5'd9; bus.cp0_wdata = 32'd0;
    next_cyc();
    bus.cp0_waddr = 5'd11; bus.cp0_wdata = 32'd5;
    next_cyc();
    bus.cp0_we = 1'b0;
    @(negedge clk);
    chk("ti_clear_on_write", 32'(bus.cp0_cause[30]), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      next_cyc();
      @(negedge clk);
      if (bus.cp0_cause[30]) begin
        found = 1'b1;
        chk("ti_count", bus.cp0_rdata, 32'd5);
      end
    end
    chk("ti_seen", 32'(found), 32'd1);
    next_cyc();
    @(negedge clk);
    chk("ti_ip7", 32'(bus.cp0_cause[15]), 32'd1);
    next_cyc();
    bus.cp0_we = 1'b1; bus.cp0_waddr = 5'd11; bus.cp0_wdata = 32'h100;
    next_cyc();
    bus.cp0_we = 1'b0;
    @(negedge clk);
    chk("ti_cleared", 32'(bus.cp0_cause[30]), 32'd0);
    next_cyc();
    @(negedge clk);
    chk("ti_ip7_off", 32'(bus.cp0_cause[15]), 32'd0);

    // Hardware interrupt lines into Cause[15:10]
    bus.int_i = 6'b000101;
    next_cyc();
    @(negedge clk);
    chk("int_ip_a", 32'(bus.cp0_cause[15:10]), 32'h05);
    bus.int_i = 6'b100000;
    next_cyc();
    @(negedge clk);
    chk("int_ip_b", 32'(bus.cp0_cause[15:10]), 32'h20);
    bus.int_i = 6'd0;

    // Count wrap
    next_cyc();
    bus.cp0_we = 1'b1; bus.cp0_waddr = 5'd9; bus.cp0_wdata = 32'hFFFFFFFF;
    next_cyc();
    bus.cp0_we = 1'b0;
    next_cyc();
    next_cyc();
    @(negedge clk);
    chk("count_wrap", bus.cp0_rdata, 32'd0);

    // Status write masking, then MTC0 colliding with a commit
    next_cyc();
    bus.cp0_we = 1'b1; bus.cp0_waddr = 5'd12; bus.cp0_wdata = 32'hFFFFFFFF;
    next_cyc();
    bus.cp0_we = 1'b0;
    @(negedge clk);
    chk("status_mask", bus.cp0_status, 32'h0040FF03);
    next_cyc();
    bus.cp0_we = 1'b1; bus.cp0_wdata = 32'h0;
    next_cyc();
    bus.cp0_we = 1'b0;
    @(negedge clk);
    chk("status_clear", bus.cp0_status, 32'h00400000);
    next_cyc();
    bus.cp0_we = 1'b1; bus.cp0_waddr = 5'd12; bus.cp0_wdata = 32'h0000FF01;
    run_trap(32'h8, 32'h80000200, 1'b0, 32'h0);
    bus.cp0_we = 1'b0;
    chk("collide_status", bus.cp0_status, 32'h00400002);
    chk("collide_flush", 32'(bus.flush), 32'd1);
    chk("collide_epc", bus.epc_o, 32'h80000200);
    chk_quiet();
    next_cyc();
    run_trap(32'hE, 32'h0, 1'b0, 32'h0);
    chk("collide_eret_rpc", bus.redirect_pc, 32'h80000200);
    chk("collide_eret_status", bus.cp0_status, 32'h00400000);
    chk_quiet();

    // Reset asserted during DRAIN
    next_cyc();
    bus.excepttype = 32'h8; bus.pcM = 32'h80000300; bus.mem_busy = 1'b1;
    next_cyc();
    bus.excepttype = 32'd0; rst = 1'b1;
    @(negedge clk);
    chk("rstd_stall", 32'(bus.stall_req), 32'd1);
    next_cyc();
    @(negedge clk);
    chk("rstd_stall_off", 32'(bus.stall_req), 32'd0);
    chk("rstd_flush", 32'(bus.flush), 32'd0);
    chk("rstd_status", bus.cp0_status, 32'h00400000);
    chk("rstd_epc", bus.epc_o, 32'h0);
    chk("rstd_cause", bus.cp0_cause, 32'h0);
    next_cyc();
    rst = 1'b0; bus.mem_busy = 1'b0;
    next_cyc();
    @(negedge clk);
    chk("rstd_after_flush", 32'(bus.flush), 32'd0);
    chk("rstd_after_rvalid", 32'(bus.redirect_valid), 32'd0);
    chk("rstd_after_stall", 32'(bus.stall_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
